// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction fetch slice.
// Holds the datapath widths, the PC increment, the fetch FSM state type,
// the FIFO entry layout, and a helper that forces word alignment on a PC.
// No ports; imported by the interface, the FIFO and the fetch unit.
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int INST_W = 32;

  localparam logic [XLEN-1:0]   PC_STEP = 32'd4;
  localparam logic [INST_W-1:0] NOP     = 32'h0000_0013;

  // FETCH: nothing in flight; WAIT: one request in flight whose data is kept;
  // DROP: one request in flight whose data must be thrown away.
  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    DROP
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  // Clears the two low address bits so every fetch address is word aligned.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of every handshake signal around the fetch stage: the instruction
// memory request/response channel, the redirect input from execute and the
// instruction channel toward the decoder.
// Modports:
//   master - the fetch unit (drives requests and the decoder channel)
//   slave  - the environment (memory, execute and decoder side)
interface fetch_unit_if;
  import riscv_pkg::*;

  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [XLEN-1:0]   imem_req_addr;
  logic              imem_rsp_valid;
  logic [INST_W-1:0] imem_rsp_data;
  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] inst;
  logic [XLEN-1:0]   inst_pc;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, inst_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Two-entry synchronous FIFO between instruction memory and the decoder.
// Ports:
//   clk, rst      - clock and asynchronous active-high reset
//   flush         - empties the FIFO (wins over push and pop)
//   push, din     - write one entry
//   pop           - consume the head entry (ignored when empty)
//   dout          - registered head entry; holds its last value when empty
//   count, valid  - occupancy and non-empty flag
module fetch_fifo #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [1:0]   count,
  output logic         valid
);

  logic [W-1:0] head;
  logic [W-1:0] tail;
  logic         pop_eff;

  assign pop_eff = pop && (count != 2'd0);
  assign dout    = head;
  assign valid   = (count != 2'd0);

  // Entries live in fixed head/tail slots; a pop shifts tail into head so the
  // decoder always sees a register output. Head is only rewritten when a real
  // entry lands there, which keeps the last value visible while empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({push, pop_eff})
        2'b10: begin
          if (count == 2'd0) head <= din;
          else               tail <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          if (count == 2'd2) head <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head <= din;
          end else begin
            head <= tail;
            tail <= din;
          end
        end
        default: ;
      endcase
    end
  end

  // The fetch credit rule should make an overflowing push impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && !flush && (count == 2'd2)));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Owns the PC, issues word fetches with at most one
// request outstanding, buffers returned words in a 2-entry FIFO and hands
// them to the decoder with their PC. A redirect flushes the FIFO and turns an
// in-flight fetch into one whose response is dropped.
// Ports:
//   clk, rst - clock and asynchronous active-high reset
//   bus      - fetch_unit_if.master: imem request/response, redirect and
//              decoder channels
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  localparam int ENTRY_W = $bits(fetch_entry_t);

  fetch_state_t       state;
  logic [XLEN-1:0]    pc;
  logic [XLEN-1:0]    req_pc;
  logic [1:0]         fifo_count;
  logic               req_fire;
  logic               rsp_keep;
  logic [ENTRY_W-1:0] fifo_dout;

  // A request may only go out when nothing is in flight and the FIFO still
  // has room for its eventual response; redirect and reset block it so the
  // next request always comes from the updated PC.
  assign bus.imem_req_valid = (state == FETCH) && (fifo_count < 2'd2) &&
                              !bus.redirect_valid && !rst;
  assign bus.imem_req_addr  = pc;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

  // Responses are enqueued only for a live request; a redirect in the same
  // cycle discards the data.
  assign rsp_keep = (state == WAIT) && bus.imem_rsp_valid && !bus.redirect_valid;

  fetch_fifo #(.W(ENTRY_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (bus.redirect_valid),
    .push  (rsp_keep),
    .din   ({req_pc, bus.imem_rsp_data}),
    .pop   (bus.inst_ready),
    .dout  (fifo_dout),
    .count (fifo_count),
    .valid (bus.inst_valid)
  );

  assign {bus.inst_pc, bus.inst} = fifo_dout;

  // PC and outstanding-request tracking. A redirect overrides everything
  // except reset; if a request is still in flight without its response, the
  // FSM parks in DROP so that response is swallowed when it arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= FETCH;
      pc     <= RESET_PC;
      req_pc <= RESET_PC;
    end else if (bus.redirect_valid) begin
      pc <= align_pc(bus.redirect_pc);
      if (state != FETCH) state <= bus.imem_rsp_valid ? FETCH : DROP;
    end else begin
      case (state)
        FETCH: begin
          if (req_fire) begin
            req_pc <= pc;
            pc     <= pc + PC_STEP;
            state  <= WAIT;
          end
        end
        WAIT:    if (bus.imem_rsp_valid) state <= FETCH;
        DROP:    if (bus.imem_rsp_valid) state <= FETCH;
        default: state <= FETCH;
      endcase
    end
  end

  // Memory must never answer when no request is outstanding.
  a_no_stray_rsp: assert property (@(posedge clk) disable iff (rst)
    !((state == FETCH) && bus.imem_rsp_valid));

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a table of per-cycle vectors for the
// basic and backpressure flows, hand sequences for redirect, reset and PC
// wrap corners, and a randomized run against a program-order reference model.
module tb_fetch_unit;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fetch_unit_if w1 ();
  fetch_unit_if w2 ();

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (w1)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk (clk),
    .rst (rst),
    .bus (w2)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit          rst_before;
    bit          req_ready;
    bit          rsp_valid;
    logic [31:0] rsp_addr;
    bit          inst_ready;
    bit          exp_req_valid;
    logic [31:0] exp_req_addr;
    bit          exp_inst_valid;
    bit          chk_inst;
    logic [31:0] exp_inst_pc;
  } vec_t;

  vec_t vecs[$];

  // Memory contents: address 0 holds addi x1,x0,5 and every word differs.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0050_0093 + (a << 5);
  endfunction

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_stimulus(input bit ready, input bit rsp_v, input logic [31:0] rsp_d,
                                input bit ir, input bit rdr, input logic [31:0] rpc);
    w1.imem_req_ready = ready;
    w1.imem_rsp_valid = rsp_v;
    w1.imem_rsp_data  = rsp_d;
    w1.inst_ready     = ir;
    w1.redirect_valid = rdr;
    w1.redirect_pc    = rpc;
  endtask

  // Samples on the falling edge, then moves to just after the next rising edge.
  task automatic check_output(input string tag, input bit rv, input logic [31:0] addr,
                              input bit iv, input bit chk, input logic [31:0] ipc);
    @(negedge clk);
    check_eq({tag, ".req_valid"}, 32'(w1.imem_req_valid), 32'(rv));
    check_eq({tag, ".req_addr"}, w1.imem_req_addr, addr);
    check_eq({tag, ".inst_valid"}, 32'(w1.inst_valid), 32'(iv));
    if (chk) begin
      check_eq({tag, ".inst_pc"}, w1.inst_pc, ipc);
      check_eq({tag, ".inst"}, w1.inst, mem_word(ipc));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    apply_stimulus(0, 0, 32'h0, 0, 0, 32'h0);
    w2.imem_req_ready = 1'b0;
    w2.imem_rsp_valid = 1'b0;
    w2.imem_rsp_data  = 32'h0;
    w2.inst_ready     = 1'b0;
    w2.redirect_valid = 1'b0;
    w2.redirect_pc    = 32'h0;
    #1;
    check_eq("rst.req_valid", 32'(w1.imem_req_valid), 32'h0);
    check_eq("rst.inst_valid", 32'(w1.inst_valid), 32'h0);
    check_eq("rst.inst", w1.inst, 32'h0);
    check_eq("rst.inst_pc", w1.inst_pc, 32'h0);
    check_eq("rst.req_addr", w1.imem_req_addr, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit          outstanding;
    int          due;
    int          cyc;
    int          consumed;
    bit          redir_prev;
    bit          rsp_v;
    bit          rdr;
    bit          rdy;
    logic [31:0] rpc;
    logic [31:0] pend_addr;
    logic [31:0] exp_req;
    logic [31:0] exp_pc;

    // Basic flow with k=1, then decoder backpressure filling the FIFO.
    vecs.push_back('{1, 1, 0, 32'h0, 1, 1, 32'h0, 0, 0, 32'h0});
    vecs.push_back('{0, 1, 1, 32'h0, 1, 0, 32'h4, 0, 0, 32'h0});
    vecs.push_back('{0, 1, 0, 32'h0, 1, 1, 32'h4, 1, 1, 32'h0});
    vecs.push_back('{1, 1, 0, 32'h0, 0, 1, 32'h0, 0, 0, 32'h0});
    vecs.push_back('{0, 1, 1, 32'h0, 0, 0, 32'h4, 0, 0, 32'h0});
    vecs.push_back('{0, 1, 0, 32'h0, 0, 1, 32'h4, 1, 1, 32'h0});
    vecs.push_back('{0, 1, 1, 32'h4, 0, 0, 32'h8, 1, 1, 32'h0});
    vecs.push_back('{0, 1, 0, 32'h0, 0, 0, 32'h8, 1, 1, 32'h0});
    vecs.push_back('{0, 1, 0, 32'h0, 0, 0, 32'h8, 1, 1, 32'h0});
    vecs.push_back('{0, 1, 0, 32'h0, 1, 0, 32'h8, 1, 1, 32'h0});
    vecs.push_back('{0, 1, 0, 32'h0, 1, 1, 32'h8, 1, 1, 32'h4});
    vecs.push_back('{0, 1, 1, 32'h8, 1, 0, 32'hC, 0, 1, 32'h4});
    vecs.push_back('{0, 1, 0, 32'h0, 1, 1, 32'hC, 1, 1, 32'h8});

    foreach (vecs[i]) begin
      if (vecs[i].rst_before) do_reset();
      apply_stimulus(vecs[i].req_ready, vecs[i].rsp_valid, mem_word(vecs[i].rsp_addr),
                     vecs[i].inst_ready, 0, 32'h0);
      check_output($sformatf("vec%0d", i), vecs[i].exp_req_valid, vecs[i].exp_req_addr,
                   vecs[i].exp_inst_valid, vecs[i].chk_inst, vecs[i].exp_inst_pc);
    end

    // Redirect while WAIT; the old response arrives three cycles later.
    do_reset();
    apply_stimulus(1, 0, 32'h0, 1, 0, 32'h0);           check_output("rd0", 1, 32'h0,   0, 0, 0);
    apply_stimulus(1, 0, 32'h0, 1, 1, 32'h100);         check_output("rd1", 0, 32'h4,   0, 0, 0);
    apply_stimulus(1, 0, 32'h0, 1, 0, 32'h0);           check_output("rd2", 0, 32'h100, 0, 0, 0);
    apply_stimulus(1, 0, 32'h0, 1, 0, 32'h0);           check_output("rd3", 0, 32'h100, 0, 0, 0);
    apply_stimulus(1, 1, mem_word(32'h0), 1, 0, 32'h0); check_output("rd4", 0, 32'h100, 0, 0, 0);
    apply_stimulus(1, 0, 32'h0, 1, 0, 32'h0);           check_output("rd5", 1, 32'h100, 0, 0, 0);
    apply_stimulus(1, 1, mem_word(32'h100), 1, 0, 32'h0); check_output("rd6", 0, 32'h104, 0, 0, 0);
    apply_stimulus(1, 0, 32'h0, 0, 0, 32'h0);           check_output("rd7", 1, 32'h104, 1, 1, 32'h100);

    // Redirect to an unaligned PC in the same cycle as a WAIT response, FIFO holding one.
    do_reset();
    apply_stimulus(1, 0, 32'h0, 0, 0, 32'h0);             check_output("rs0", 1, 32'h0,   0, 0, 0);
    apply_stimulus(1, 1, mem_word(32'h0), 0, 0, 32'h0);   check_output("rs1", 0, 32'h4,   0, 0, 0);
    apply_stimulus(1, 0, 32'h0, 0, 0, 32'h0);             check_output("rs2", 1, 32'h4,   1, 1, 32'h0);
    apply_stimulus(1, 1, mem_word(32'h4), 0, 1, 32'h203); check_output("rs3", 0, 32'h8,   1, 1, 32'h0);
    apply_stimulus(1, 0, 32'h0, 0, 0, 32'h0);             check_output("rs4", 1, 32'h200, 0, 0, 0);
    apply_stimulus(1, 1, mem_word(32'h200), 0, 0, 32'h0); check_output("rs5", 0, 32'h204, 0, 0, 0);
    apply_stimulus(1, 0, 32'h0, 0, 0, 32'h0);             check_output("rs6", 1, 32'h204, 1, 1, 32'h200);

    // Reset while WAIT with one buffered entry; memory restarts with this block.
    do_reset();
    apply_stimulus(1, 0, 32'h0, 0, 0, 32'h0);           check_output("rw0", 1, 32'h0, 0, 0, 0);
    apply_stimulus(1, 1, mem_word(32'h0), 0, 0, 32'h0); check_output("rw1", 0, 32'h4, 0, 0, 0);
    apply_stimulus(1, 0, 32'h0, 0, 0, 32'h0);           check_output("rw2", 1, 32'h4, 1, 1, 32'h0);
    do_reset();
    apply_stimulus(1, 0, 32'h0, 0, 0, 32'h0);           check_output("rw3", 1, 32'h0, 0, 0, 0);
    apply_stimulus(1, 1, mem_word(32'h0), 0, 0, 32'h0); check_output("rw4", 0, 32'h4, 0, 0, 0);
    apply_stimulus(1, 0, 32'h0, 0, 0, 32'h0);           check_output("rw5", 1, 32'h4, 1, 1, 32'h0);

    // PC wrap on the instance that starts at the top of the address space.
    do_reset();
    w2.imem_req_ready = 1'b1;
    w2.inst_ready     = 1'b1;
    for (int c = 0; c < 5; c++) begin
      w2.imem_rsp_valid = (c == 1) || (c == 3);
      w2.imem_rsp_data  = mem_word((c == 1) ? 32'hFFFF_FFFC : 32'h0);
      @(negedge clk);
      if (c == 0) check_eq("wrap.addr0", w2.imem_req_addr, 32'hFFFF_FFFC);
      if (c == 0) check_eq("wrap.rv0", 32'(w2.imem_req_valid), 32'h1);
      if (c == 2) check_eq("wrap.addr1", w2.imem_req_addr, 32'h0);
      if (c == 2) check_eq("wrap.rv1", 32'(w2.imem_req_valid), 32'h1);
      if (c == 2) check_eq("wrap.pc0", w2.inst_pc, 32'hFFFF_FFFC);
      if (c == 2) check_eq("wrap.inst0", w2.inst, mem_word(32'hFFFF_FFFC));
      if (c == 4) check_eq("wrap.iv1", 32'(w2.inst_valid), 32'h1);
      if (c == 4) check_eq("wrap.pc1", w2.inst_pc, 32'h0);
      if (c == 4) check_eq("wrap.inst1", w2.inst, mem_word(32'h0));
      @(posedge clk);
      #1;
    end
    w2.imem_rsp_valid = 1'b0;
    w2.imem_req_ready = 1'b0;

    // Random traffic against a program-order model: the decoder must see
    // consecutive PCs from the last redirect, and requests follow the same order.
    do_reset();
    outstanding = 0; due = 0; cyc = 0; consumed = 0; redir_prev = 0;
    pend_addr = 32'h0; exp_req = 32'h0; exp_pc = 32'h0;
    for (int n = 0; n < 3000; n++) begin
      rsp_v = outstanding && (cyc == due);
      rdr   = !redir_prev && ($urandom_range(0, 29) == 0);
      rpc   = $urandom;
      rdy   = ($urandom_range(0, 3) != 0);
      apply_stimulus(rdy, rsp_v, mem_word(pend_addr), ($urandom_range(0, 2) != 0), rdr, rpc);
      @(negedge clk);
      if (redir_prev) check_eq("rnd.iv_after_redirect", 32'(w1.inst_valid), 32'h0);
      if (rdr) check_eq("rnd.rv_during_redirect", 32'(w1.imem_req_valid), 32'h0);
      if (w1.imem_req_valid) check_eq("rnd.single_outstanding", 32'(outstanding), 32'h0);
      if (w1.inst_valid && w1.inst_ready) begin
        check_eq("rnd.inst_pc", w1.inst_pc, exp_pc);
        check_eq("rnd.inst", w1.inst, mem_word(exp_pc));
        exp_pc   = exp_pc + 32'd4;
        consumed++;
      end
      if (rsp_v) outstanding = 0;
      if (w1.imem_req_valid && rdy) begin
        check_eq("rnd.req_addr", w1.imem_req_addr, exp_req);
        outstanding = 1;
        pend_addr   = w1.imem_req_addr;
        due         = cyc + int'($urandom_range(1, 3));
        exp_req     = exp_req + 32'd4;
      end
      if (rdr) begin
        exp_pc  = rpc & ~32'h3;
        exp_req = rpc & ~32'h3;
      end
      redir_prev = rdr;
      @(posedge clk);
      #1;
      cyc++;
    end
    check_eq("rnd.progress", 32'(consumed > 100), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
